// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end.
// Keeps up to MAX_OUTSTANDING requests in flight to program memory and buffers
// returned instructions with their PCs in a DEPTH-entry FIFO for decode.
// A redirect flushes the FIFO, retargets fetch and discards stale responses.
module fetch_queue #(
  parameter int                  PC_WIDTH        = 32,
  parameter int                  INST_WIDTH      = 32,
  parameter int                  DEPTH           = 4,
  parameter int                  MAX_OUTSTANDING = 2,
  parameter int                  PC_STEP         = 4,
  parameter logic [PC_WIDTH-1:0] RESET_PC        = {PC_WIDTH{1'b0}}
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  output logic                       req_valid_out,
  input  logic                       req_ready_in,
  output logic [PC_WIDTH-1:0]        req_addr_out,
  input  logic                       resp_valid_in,
  input  logic [INST_WIDTH-1:0]      resp_inst_in,
  output logic                       f2d_valid_out,
  output logic [PC_WIDTH-1:0]        f2d_pc_out,
  output logic [INST_WIDTH-1:0]      f2d_inst_out,
  input  logic                       deq_in,
  input  logic                       redirect_in,
  input  logic [PC_WIDTH-1:0]        redirect_pc_in,
  output logic [$clog2(DEPTH):0]     occupancy_out
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int CRD_W = CNT_W + 1;
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [PC_WIDTH-1:0]   fetch_pc_r, fetch_pc_nx_s;
  logic [PC_WIDTH-1:0]   resp_pc_r, resp_pc_nx_s;
  logic [OUT_W-1:0]      outstanding_r, outstanding_nx_s;
  logic [OUT_W-1:0]      drop_cnt_r, drop_cnt_nx_s;
  logic [PTR_W-1:0]      head_r, head_nx_s;
  logic [PTR_W-1:0]      tail_r, tail_nx_s;
  logic [CNT_W-1:0]      count_r, count_nx_s;
  logic [PC_WIDTH-1:0]   pc_mem_r   [DEPTH];
  logic [INST_WIDTH-1:0] inst_mem_r [DEPTH];

  logic [CRD_W-1:0]      credit_s;
  logic                  req_valid_s;
  logic                  issue_s;
  logic                  push_s;
  logic                  pop_s;

  // Handshake qualifiers; credits count FIFO entries plus kept responses still in flight.
  always_comb begin
    credit_s    = CRD_W'(count_r) + CRD_W'(outstanding_r) - CRD_W'(drop_cnt_r);
    req_valid_s = rst_in && !redirect_in &&
                  (outstanding_r < OUT_W'(MAX_OUTSTANDING)) &&
                  (credit_s < CRD_W'(DEPTH));
    issue_s     = req_valid_s && req_ready_in;
    push_s      = resp_valid_in && (drop_cnt_r == {OUT_W{1'b0}}) && !redirect_in;
    pop_s       = deq_in && (count_r != {CNT_W{1'b0}}) && !redirect_in;
  end

  // Next-state computation; a redirect overrides issue, push and pop.
  always_comb begin
    fetch_pc_nx_s    = fetch_pc_r;
    resp_pc_nx_s     = resp_pc_r;
    drop_cnt_nx_s    = drop_cnt_r;
    head_nx_s        = head_r;
    tail_nx_s        = tail_r;
    count_nx_s       = count_r;
    outstanding_nx_s = outstanding_r + OUT_W'(issue_s) - OUT_W'(resp_valid_in);
    if (redirect_in) begin
      fetch_pc_nx_s = redirect_pc_in;
      resp_pc_nx_s  = redirect_pc_in;
      drop_cnt_nx_s = outstanding_r - OUT_W'(resp_valid_in);
      head_nx_s     = {PTR_W{1'b0}};
      tail_nx_s     = {PTR_W{1'b0}};
      count_nx_s    = {CNT_W{1'b0}};
    end else begin
      if (issue_s) begin
        fetch_pc_nx_s = fetch_pc_r + PC_WIDTH'(PC_STEP);
      end else begin
        fetch_pc_nx_s = fetch_pc_r;
      end
      if (resp_valid_in && (drop_cnt_r != {OUT_W{1'b0}})) begin
        drop_cnt_nx_s = drop_cnt_r - {{(OUT_W-1){1'b0}}, 1'b1};
      end else begin
        drop_cnt_nx_s = drop_cnt_r;
      end
      if (push_s) begin
        resp_pc_nx_s = resp_pc_r + PC_WIDTH'(PC_STEP);
        tail_nx_s    = tail_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end else begin
        resp_pc_nx_s = resp_pc_r;
        tail_nx_s    = tail_r;
      end
      if (pop_s) begin
        head_nx_s = head_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end else begin
        head_nx_s = head_r;
      end
      count_nx_s = count_r + CNT_W'(push_s) - CNT_W'(pop_s);
    end
  end

  // Control state registers.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      fetch_pc_r    <= RESET_PC;
      resp_pc_r     <= RESET_PC;
      outstanding_r <= {OUT_W{1'b0}};
      drop_cnt_r    <= {OUT_W{1'b0}};
      head_r        <= {PTR_W{1'b0}};
      tail_r        <= {PTR_W{1'b0}};
      count_r       <= {CNT_W{1'b0}};
    end else begin
      fetch_pc_r    <= fetch_pc_nx_s;
      resp_pc_r     <= resp_pc_nx_s;
      outstanding_r <= outstanding_nx_s;
      drop_cnt_r    <= drop_cnt_nx_s;
      head_r        <= head_nx_s;
      tail_r        <= tail_nx_s;
      count_r       <= count_nx_s;
    end
  end

  // FIFO storage: kept responses are written at the tail with their tagged PC.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_r[i]   <= {PC_WIDTH{1'b0}};
        inst_mem_r[i] <= {INST_WIDTH{1'b0}};
      end
    end else if (push_s) begin
      pc_mem_r[tail_r]   <= resp_pc_r;
      inst_mem_r[tail_r] <= resp_inst_in;
    end
  end

  assign req_valid_out = req_valid_s;
  assign req_addr_out  = fetch_pc_r;
  assign f2d_valid_out = (count_r != {CNT_W{1'b0}});
  assign f2d_pc_out    = pc_mem_r[head_r];
  assign f2d_inst_out  = inst_mem_r[head_r];
  assign occupancy_out = count_r;

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized and directed bench for fetch_queue.
// A memory model answers requests in order; a reference model tags each
// request with a redirect epoch and keeps only current-epoch responses.
module tb_fetch_queue;
  localparam int DEPTH = 4;
  localparam int MAXO  = 2;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        req_valid_out, req_ready_in = 1'b0;
  logic [31:0] req_addr_out;
  logic        resp_valid_in = 1'b0;
  logic [31:0] resp_inst_in = 32'h0;
  logic        f2d_valid_out;
  logic [31:0] f2d_pc_out, f2d_inst_out;
  logic        deq_in = 1'b0, redirect_in = 1'b0;
  logic [31:0] redirect_pc_in = 32'h0;
  logic [2:0]  occupancy_out;

  fetch_queue #(.PC_WIDTH(32), .INST_WIDTH(32), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO),
                .PC_STEP(4), .RESET_PC(32'h0)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .req_valid_out(req_valid_out), .req_ready_in(req_ready_in), .req_addr_out(req_addr_out),
    .resp_valid_in(resp_valid_in), .resp_inst_in(resp_inst_in),
    .f2d_valid_out(f2d_valid_out), .f2d_pc_out(f2d_pc_out), .f2d_inst_out(f2d_inst_out),
    .deq_in(deq_in), .redirect_in(redirect_in), .redirect_pc_in(redirect_pc_in),
    .occupancy_out(occupancy_out));

  initial forever #5 clk_in = ~clk_in;

  typedef struct { logic [31:0] addr; logic [31:0] mpc; int due; int ep; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
  req_t mem_q[$];
  ent_t sb[$];
  int cyc = 0, lat = 1, cur_epoch = 0, issue_cnt = 0;
  logic [31:0] exp_fetch_pc = 32'h0;
  int n_checks = 0, n_fail = 0;
  bit seen200 = 1'b0;
  bit s_live = 1'b0, s_issue, s_resp, s_deq, s_redir;
  logic [31:0] s_addr, s_rpc;

  function automatic logic [31:0] inst_of(logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int cur_inflight();
    int n = 0;
    foreach (mem_q[i]) if (mem_q[i].ep == cur_epoch) n++;
    return n;
  endfunction

  // Monitor: compare DUT outputs with the model mid-cycle and capture this cycle's events.
  initial forever begin
    @(negedge clk_in);
    if (!rst_in) begin
      chk("rst_req_valid", {31'b0, req_valid_out}, 32'h0);
      chk("rst_f2d_valid", {31'b0, f2d_valid_out}, 32'h0);
      chk("rst_occupancy", {29'b0, occupancy_out}, 32'h0);
      s_live = 1'b0;
    end else begin
      bit exp_rv;
      exp_rv = !redirect_in && (mem_q.size() < MAXO) && ((sb.size() + cur_inflight()) < DEPTH);
      chk("req_valid", {31'b0, req_valid_out}, {31'b0, exp_rv});
      if (exp_rv && req_valid_out) chk("req_addr", req_addr_out, exp_fetch_pc);
      chk("occupancy", {29'b0, occupancy_out}, sb.size());
      chk("f2d_valid", {31'b0, f2d_valid_out}, {31'b0, sb.size() != 0});
      if (sb.size() != 0 && f2d_valid_out) begin
        chk("f2d_pc", f2d_pc_out, sb[0].pc);
        chk("f2d_inst", f2d_inst_out, sb[0].inst);
      end
      if (f2d_valid_out && f2d_pc_out[31:8] == 24'h2) seen200 = 1'b1;
      s_live  = 1'b1;
      s_issue = req_valid_out && req_ready_in;
      s_addr  = req_addr_out;
      s_resp  = resp_valid_in;
      s_deq   = deq_in;
      s_redir = redirect_in;
      s_rpc   = redirect_pc_in;
    end
  end

  // Reference model: apply the captured cycle at each clock edge; reset wipes everything.
  initial forever begin
    @(posedge clk_in or negedge rst_in);
    if (!rst_in) begin
      mem_q.delete();
      sb.delete();
      exp_fetch_pc = 32'h0;
    end else if (s_live) begin
      req_t h;
      if (s_deq && !s_redir && sb.size() > 0) void'(sb.pop_front());
      if (s_resp && mem_q.size() > 0) begin
        h = mem_q.pop_front();
        if (!s_redir && h.ep == cur_epoch) sb.push_back('{pc: h.mpc, inst: inst_of(h.addr)});
      end
      if (s_issue) begin
        mem_q.push_back('{addr: s_addr, mpc: exp_fetch_pc, due: cyc + lat, ep: cur_epoch});
        exp_fetch_pc = exp_fetch_pc + 32'd4;
        issue_cnt++;
      end
      if (s_redir) begin
        sb.delete();
        cur_epoch++;
        exp_fetch_pc = s_rpc;
      end
      s_live = 1'b0;
      cyc++;
    end
  end

  // One cycle of stimulus; memory answers the oldest request once its latency has elapsed.
  task automatic step(bit deq, bit rdy, bit redir, logic [31:0] rpc);
    @(posedge clk_in);
    #2;
    deq_in = deq; req_ready_in = rdy; redirect_in = redir; redirect_pc_in = rpc;
    if (rst_in && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      resp_valid_in = 1'b1;
      resp_inst_in  = inst_of(mem_q[0].addr);
    end else begin
      resp_valid_in = 1'b0;
      resp_inst_in  = $urandom;
    end
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] spc;
    int ic;
    bit found;
    repeat (3) step(1'b0, 1'b1, 1'b0, 32'h0);
    @(posedge clk_in); #2; rst_in = 1'b1;

    // Streaming: latency 1, always ready, always dequeue.
    spc = 32'h0;
    for (int i = 0; i < 24; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      if (i >= 4) chk("stream_valid", {31'b0, f2d_valid_out}, 32'h1);
      if (f2d_valid_out) begin chk("stream_pc", f2d_pc_out, spc); spc = spc + 32'd4; end
    end

    // Fill and stall, then one dequeue releases exactly one request.
    repeat (12) step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("fill_occ", {29'b0, occupancy_out}, 32'd4);
    chk("fill_req_valid", {31'b0, req_valid_out}, 32'h0);
    ic = issue_cnt;
    step(1'b1, 1'b1, 1'b0, 32'h0);
    repeat (6) step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("one_issue", issue_cnt - ic, 32'd1);
    chk("refill_occ", {29'b0, occupancy_out}, 32'd4);

    // Redirect to 0x100 with two requests in flight at latency 3.
    step(1'b1, 1'b1, 1'b1, 32'h1000);
    lat = 3;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      if (mem_q.size() == 2) found = 1'b1;
    end
    chk("two_inflight", {31'b0, found}, 32'h1);
    redirect_in = 1'b1; redirect_pc_in = 32'h100;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b0, 1'b1, 1'b0, 32'h0);
      if (f2d_valid_out) found = 1'b1;
    end
    chk("rd100_seen", {31'b0, found}, 32'h1);
    chk("rd100_pc", f2d_pc_out, 32'h100);
    chk("rd100_inst", f2d_inst_out, inst_of(32'h100));

    // Redirect coincident with a response and a dequeue.
    lat = 2;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      step($urandom_range(0, 1) == 1, 1'b1, 1'b0, 32'h0);
      if (resp_valid_in && sb.size() > 0 && mem_q.size() >= 2) found = 1'b1;
    end
    chk("coinc_found", {31'b0, found}, 32'h1);
    redirect_in = 1'b1; deq_in = 1'b1; redirect_pc_in = 32'h400;
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("coinc_occ", {29'b0, occupancy_out}, 32'h0);
    for (int i = 0; i < 20 && mem_q.size() > 0; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("coinc_drained", mem_q.size(), 32'h0);
    chk("coinc_all_dropped", {29'b0, occupancy_out}, 32'h0);

    // Back-to-back redirects while drops are pending.
    lat = 3;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      if (mem_q.size() == 2) found = 1'b1;
    end
    redirect_in = 1'b1; redirect_pc_in = 32'h200;
    step(1'b0, 1'b1, 1'b1, 32'h300);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b0, 1'b1, 1'b0, 32'h0);
      if (f2d_valid_out) found = 1'b1;
    end
    chk("rd300_seen", {31'b0, found}, 32'h1);
    chk("rd300_pc", f2d_pc_out, 32'h300);

    // Async reset with three entries buffered.
    lat = 1;
    step(1'b0, 1'b1, 1'b1, 32'h2000);
    for (int i = 0; i < 20 && sb.size() != 3; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("pre_rst_occ", {29'b0, occupancy_out}, 32'd3);
    rst_in = 1'b0; resp_valid_in = 1'b0;
    #1;
    chk("async_f2d_valid", {31'b0, f2d_valid_out}, 32'h0);
    chk("async_req_valid", {31'b0, req_valid_out}, 32'h0);
    repeat (2) step(1'b0, 1'b1, 1'b0, 32'h0);
    @(posedge clk_in); #2; rst_in = 1'b1; #1;
    chk("restart_valid", {31'b0, req_valid_out}, 32'h1);
    chk("restart_addr", req_addr_out, 32'h0);
    repeat (8) step(1'b1, 1'b1, 1'b0, 32'h0);

    // PC wrap-around, then randomized traffic.
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
    repeat (12) step(1'b1, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 49) == 0) lat = $urandom_range(1, 4);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 31) == 0, $urandom & 32'hFFFF_FFFC);
    end
    chk("no_0x200_path", {31'b0, seen200}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch front end that replaces the single-slot fetch stage of the CPU. It keeps up to MAX_OUTSTANDING requests in flight to program memory, buffers returned instructions with their PCs in a DEPTH-entry FIFO, and presents them to decode through a valid/dequeue handshake. A redirect from execute flushes the FIFO, retargets the fetch PC and silently discards every response still in flight from the old path.

## Interface

**Parameters**
- PC_WIDTH, 32: width of all PCs and addresses.
- INST_WIDTH, 32: instruction width.
- DEPTH, 4: FIFO entries. Power of two, ≥2.
- MAX_OUTSTANDING, 2: maximum issued-but-unreturned requests. Range 1..DEPTH.
- PC_STEP, 4: PC increment per instruction.
- RESET_PC, 0: first fetch address after reset.

**Ports**
- clk_in, input, 1: clock. All state updates on the rising edge.
- rst_in, input, 1: reset. Asynchronous, active-low.
- req_valid_out, output, 1: fetch request valid.
- req_ready_in, input, 1: memory accepts the request. A request is issued when req_valid_out && req_ready_in.
- req_addr_out, output, PC_WIDTH: fetch address.
- resp_valid_in, input, 1: response valid. Responses return in order, at least 1 cycle after issue. There is no backpressure.
- resp_inst_in, input, INST_WIDTH: returned instruction.
- f2d_valid_out, output, 1: FIFO head is valid.
- f2d_pc_out, output, PC_WIDTH: PC of the head.
- f2d_inst_out, output, INST_WIDTH: instruction at the head.
- deq_in, input, 1: decode consumes the head this cycle.
- redirect_in, input, 1: flush and refetch.
- redirect_pc_in, input, PC_WIDTH: new fetch PC.
- occupancy_out, output, $clog2(DEPTH)+1: current FIFO entry count.

## Operation

**State**
- fetch_pc: next address to request.
- resp_pc: PC to tag the next kept response with.
- outstanding: requests in flight, including doomed ones.
- drop_cnt: in-flight responses still to discard.
- FIFO: head/tail pointers and count, with wrap-around at DEPTH.

**Request issue**
- req_valid_out = !redirect_in && outstanding < MAX_OUTSTANDING && (count + outstanding - drop_cnt) < DEPTH.
- The last condition is the credit rule. It guarantees every kept response has a free slot, so the FIFO can never overflow.
- req_addr_out = fetch_pc.
- On issue: fetch_pc += PC_STEP, outstanding += 1.

**Response handling**
- Each resp_valid_in decrements outstanding.
- If drop_cnt > 0: the response is discarded and drop_cnt -= 1.
- Otherwise: {resp_pc, resp_inst_in} is pushed at the tail and resp_pc += PC_STEP.

**Dequeue**
- deq_in with count > 0 pops the head.
- deq_in while empty is ignored.
- Push and pop in the same cycle leave count unchanged.

**Redirect** (highest priority)
- FIFO count is cleared and pointers are reset.
- fetch_pc and resp_pc are set to redirect_pc_in.
- No request issues that cycle.
- Any response arriving that cycle is discarded.
- drop_cnt <= outstanding - resp_valid_in, and outstanding <= outstanding - resp_valid_in.
- deq_in is ignored in a redirect cycle.
- A redirect while drop_cnt > 0 recomputes drop_cnt by the same formula; it does not accumulate.

**Arithmetic and wrap**
- PC arithmetic wraps modulo 2^PC_WIDTH.
- FIFO pointers wrap modulo DEPTH.

**Reset** (async assert, sync-safe deassert)
- fetch_pc = resp_pc = RESET_PC.
- outstanding = drop_cnt = 0, FIFO empty.
- req_valid_out = 0 while reset is asserted, f2d_valid_out = 0, occupancy_out = 0.
- Reset mid-operation abandons in-flight requests. The memory side is reset by the same rst_in.

## Timing

- First request: req_valid_out rises in the first cycle after rst_in deasserts, with req_addr_out = RESET_PC.
- Issue rate: one request per cycle when credits allow.
- Response to decode: a response accepted in cycle t is visible on f2d_* in cycle t+1. The FIFO outputs are registered and there is no bypass.
- Redirect: redirect_in in cycle t gives f2d_valid_out = 0 in t+1 and req_valid_out = 1 with req_addr_out = redirect_pc_in in t+1, if credits allow.
- req_valid_out depends combinationally on redirect_in and registered state only. It must not depend on req_ready_in.
- f2d_* depend on registered state only.

## Test plan

1. **Reset and streaming.** Release rst_in with memory latency 1 and always ready, and hold deq_in = 1.
   - Required: requests at 0x0, 0x4, 0x8, …; f2d_pc_out sequence 0x0, 0x4, …; sustained one instruction per cycle.
2. **Fill and stall.** DEPTH=4 with deq_in = 0.
   - Required: occupancy_out saturates at 4 with no overflow, and req_valid_out = 0 once credits are exhausted.
   - Then assert deq_in for one cycle: exactly one new request issues.
3. **Redirect with two in flight.** Latency 3, MAX_OUTSTANDING=2, redirect to 0x100 while 2 requests are outstanding.
   - Required: both old responses are discarded, and the first f2d_pc_out after the redirect is 0x100 with the instruction returned for address 0x100.
4. **Redirect coincident with a response and a deq.**
   - Required: that response is discarded, deq_in has no effect, drop_cnt = outstanding - 1, and occupancy_out = 0 next cycle.
5. **Back-to-back redirects.** Redirect to 0x200, then to 0x300 the next cycle, while drops are pending.
   - Required: no 0x200-path instruction ever appears on f2d, and the first valid f2d_pc_out is 0x300.
6. **Async reset mid-stream.** Assert rst_in between clock edges with the FIFO holding 3 entries.
   - Required: f2d_valid_out and req_valid_out go to 0 immediately, without waiting for a clock edge.
   - After release, fetch restarts at RESET_PC.
